// File: rtl/bcd_count_ctrl_pkg.sv
// Shared types and constants for the BCD counter-chain controller.
package bcd_count_ctrl_pkg;

    localparam int BCD_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAUSE,
        ST_CLR,
        ST_SAT
    } state_e;

    function automatic int presc_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/bcd_count_ctrl_if.sv
// Command/status bundle between user command logic, the BCD chain and the controller.
interface bcd_count_ctrl_if
    import bcd_count_ctrl_pkg::*;
#(
    parameter int DIGITS = 3
);
    logic                      start_stop;
    logic                      clear;
    logic                      lap;
    logic                      cnt_done;
    logic [BCD_W*DIGITS-1:0]   cnt_digits;
    logic                      cnt_en;
    logic                      cnt_clr;
    logic [BCD_W*DIGITS-1:0]   lap_digits;
    logic                      lap_valid;
    logic                      running;
    logic                      overflow;

    modport master (
        output start_stop, clear, lap, cnt_done, cnt_digits,
        input  cnt_en, cnt_clr, lap_digits, lap_valid, running, overflow
    );

    modport slave (
        input  start_stop, clear, lap, cnt_done, cnt_digits,
        output cnt_en, cnt_clr, lap_digits, lap_valid, running, overflow
    );
endinterface

// File: rtl/bcd_count_ctrl_tick_prescaler.sv
// Modulo-TICK_DIV phase counter; holds when not counting so a paused run resumes in phase.
module bcd_count_ctrl_tick_prescaler
    import bcd_count_ctrl_pkg::*;
#(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic count_i,
    input  logic clear_i,
    output logic tc_o
);
    localparam int            W    = presc_width(TICK_DIV);
    localparam logic [W-1:0]  LAST = W'(TICK_DIV - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (count_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == LAST);

endmodule

// File: rtl/bcd_count_ctrl.sv
// Run/pause/clear sequencer for a cascaded BCD decade-counter chain, with
// prescaled count enable, rollover/saturation handling and lap snapshots.
module bcd_count_ctrl
    import bcd_count_ctrl_pkg::*;
#(
    parameter int TICK_DIV = 4,
    parameter int DIGITS   = 3,
    parameter int WRAP     = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    bcd_count_ctrl_if.slave  bus
);
    state_e                    state_q, state_d;
    logic                      running_q;
    logic                      cnt_clr_q;
    logic                      overflow_q;
    logic                      lap_valid_q;
    logic [BCD_W*DIGITS-1:0]   lap_digits_q;

    logic presc_tc;
    logic tick;
    logic rollover;
    logic lap_capture;

    bcd_count_ctrl_tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk      (clk),
        .reset_n  (reset_n),
        .count_i  (state_q == ST_RUN),
        .clear_i  (bus.clear),
        .tc_o     (presc_tc)
    );

    assign tick     = (state_q == ST_RUN) && presc_tc;
    assign rollover = tick && bus.cnt_done;

    // Saturating mode withholds the rollover pulse so the chain parks at all nines.
    assign bus.cnt_en = tick && !((WRAP == 0) && bus.cnt_done);

    assign lap_capture = bus.lap && !bus.clear &&
                         (state_q inside {ST_RUN, ST_PAUSE, ST_SAT});

    always_comb begin
        state_d = state_q;
        if (bus.clear) begin
            state_d = ST_CLR;
        end else begin
            unique case (state_q)
                ST_IDLE:  if (bus.start_stop) state_d = ST_RUN;
                ST_RUN: begin
                    if (rollover && (WRAP == 0)) begin
                        state_d = ST_SAT;
                    end else if (bus.start_stop) begin
                        state_d = ST_PAUSE;
                    end
                end
                ST_PAUSE: if (bus.start_stop) state_d = ST_RUN;
                ST_CLR:   state_d = ST_IDLE;
                ST_SAT:   state_d = ST_SAT;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            running_q    <= 1'b0;
            cnt_clr_q    <= 1'b0;
            overflow_q   <= 1'b0;
            lap_valid_q  <= 1'b0;
            lap_digits_q <= '0;
        end else begin
            state_q     <= state_d;
            running_q   <= (state_d == ST_RUN);
            cnt_clr_q   <= (state_d == ST_CLR);
            lap_valid_q <= lap_capture;
            if (bus.clear) begin
                overflow_q <= 1'b0;
            end else if (rollover) begin
                overflow_q <= 1'b1;
            end
            if (lap_capture) begin
                lap_digits_q <= bus.cnt_digits;
            end
        end
    end

    assign bus.cnt_clr    = cnt_clr_q;
    assign bus.running    = running_q;
    assign bus.overflow   = overflow_q;
    assign bus.lap_valid  = lap_valid_q;
    assign bus.lap_digits = lap_digits_q;

endmodule

// File: tb/tb_bcd_count_ctrl.sv
// Bench for bcd_count_ctrl: a wrapping and a saturating instance share one stimulus
// stream and are checked every cycle against a run-time based behavioural model.
module tb_bcd_count_ctrl;
    localparam int TD = 4;
    localparam int ND = 3;
    localparam int DW = 4 * ND;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_CLR   = 3;
    localparam int M_SAT   = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          ss = 1'b0, cl = 1'b0, lp = 1'b0, dn = 1'b0;
    logic [DW-1:0] dg = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bcd_count_ctrl_if #(.DIGITS(ND)) if_w1 ();
    bcd_count_ctrl_if #(.DIGITS(ND)) if_w0 ();

    assign if_w1.start_stop = ss;
    assign if_w1.clear      = cl;
    assign if_w1.lap        = lp;
    assign if_w1.cnt_done   = dn;
    assign if_w1.cnt_digits = dg;
    assign if_w0.start_stop = ss;
    assign if_w0.clear      = cl;
    assign if_w0.lap        = lp;
    assign if_w0.cnt_done   = dn;
    assign if_w0.cnt_digits = dg;

    bcd_count_ctrl #(.TICK_DIV(TD), .DIGITS(ND), .WRAP(1)) dut_w1 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (if_w1.slave)
    );

    bcd_count_ctrl #(.TICK_DIV(TD), .DIGITS(ND), .WRAP(0)) dut_w0 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (if_w0.slave)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Same expectation for both instances.
    task automatic chk_both(input string name, input logic a1, input logic a0, input logic e);
        check({"wrap1.", name}, 32'(a1), 32'(e));
        check({"wrap0.", name}, 32'(a0), 32'(e));
    endtask

    task automatic drive(input logic s, input logic c, input logic l, input logic d,
                         input logic [DW-1:0] g);
        @(posedge clk);
        #1;
        ss = s; cl = c; lp = l; dn = d; dg = g;
    endtask

    // Behavioural model: phase comes from total RUN cycles since the last clear/reset.
    int            m_st   [2];
    int            m_runc [2];
    logic          m_ovf  [2];
    logic          m_lapv [2];
    logic [DW-1:0] m_lap  [2];

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_st[i] = M_IDLE; m_runc[i] = 0; m_ovf[i] = 1'b0;
            m_lapv[i] = 1'b0; m_lap[i] = '0;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic          o_en, o_clr, o_lv, o_run, o_ovf;
            logic [DW-1:0] o_ld;
            logic          tick, roll, e_en, wrap;
            string         tag;
            wrap = (i == 0);
            tag  = wrap ? "model.wrap1." : "model.wrap0.";
            if (i == 0) begin
                o_en = if_w1.cnt_en; o_clr = if_w1.cnt_clr; o_lv = if_w1.lap_valid;
                o_run = if_w1.running; o_ovf = if_w1.overflow; o_ld = if_w1.lap_digits;
            end else begin
                o_en = if_w0.cnt_en; o_clr = if_w0.cnt_clr; o_lv = if_w0.lap_valid;
                o_run = if_w0.running; o_ovf = if_w0.overflow; o_ld = if_w0.lap_digits;
            end
            if (!reset_n) begin
                m_st[i] = M_IDLE; m_runc[i] = 0; m_ovf[i] = 1'b0;
                m_lapv[i] = 1'b0; m_lap[i] = '0;
            end
            tick = (m_st[i] == M_RUN) && (m_runc[i] % TD == TD - 1) && reset_n;
            e_en = tick && !(!wrap && dn);
            check({tag, "cnt_en"},     32'(o_en),  32'(e_en));
            check({tag, "cnt_clr"},    32'(o_clr), 32'(m_st[i] == M_CLR));
            check({tag, "running"},    32'(o_run), 32'(m_st[i] == M_RUN));
            check({tag, "overflow"},   32'(o_ovf), 32'(m_ovf[i]));
            check({tag, "lap_valid"},  32'(o_lv),  32'(m_lapv[i]));
            check({tag, "lap_digits"}, 32'(o_ld),  32'(m_lap[i]));
            if (reset_n) begin
                roll = tick && dn;
                if (cl) begin
                    m_st[i] = M_CLR; m_runc[i] = 0; m_ovf[i] = 1'b0; m_lapv[i] = 1'b0;
                end else begin
                    m_lapv[i] = lp && (m_st[i] == M_RUN || m_st[i] == M_PAUSE || m_st[i] == M_SAT);
                    if (m_lapv[i]) m_lap[i] = dg;
                    if (roll) m_ovf[i] = 1'b1;
                    case (m_st[i])
                        M_IDLE:  if (ss) m_st[i] = M_RUN;
                        M_RUN: begin
                            m_runc[i]++;
                            if (roll && !wrap) m_st[i] = M_SAT;
                            else if (ss)       m_st[i] = M_PAUSE;
                        end
                        M_PAUSE: if (ss) m_st[i] = M_RUN;
                        M_CLR:   m_st[i] = M_IDLE;
                        default: m_st[i] = m_st[i];
                    endcase
                end
            end
        end
    end

    initial begin
        logic [12:0] pulse_mask;
        pulse_mask = 13'b1_0001_0001_0000;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_both("rst.cnt_en",    if_w1.cnt_en,    if_w0.cnt_en,    1'b0);
        chk_both("rst.cnt_clr",   if_w1.cnt_clr,   if_w0.cnt_clr,   1'b0);
        chk_both("rst.running",   if_w1.running,   if_w0.running,   1'b0);
        chk_both("rst.overflow",  if_w1.overflow,  if_w0.overflow,  1'b0);
        chk_both("rst.lap_valid", if_w1.lap_valid, if_w0.lap_valid, 1'b0);
        check("rst.lap_digits", 32'(if_w1.lap_digits), 32'h0);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Start at cycle 0: pulses expected at cycles 4, 8, 12.
        drive(1, 0, 0, 0, '0);
        @(negedge clk);
        chk_both("start.running_c0", if_w1.running, if_w0.running, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            drive(0, 0, 0, 0, '0);
            @(negedge clk);
            chk_both("start.running", if_w1.running, if_w0.running, 1'b1);
            chk_both("start.cnt_en",  if_w1.cnt_en,  if_w0.cnt_en,  pulse_mask[k]);
        end

        drive(0, 1, 0, 0, '0);
        drive(0, 0, 0, 0, '0);
        @(negedge clk);
        chk_both("clr.cnt_clr", if_w1.cnt_clr, if_w0.cnt_clr, 1'b1);
        chk_both("clr.running", if_w1.running, if_w0.running, 1'b0);
        drive(0, 0, 0, 0, '0);
        @(negedge clk);
        chk_both("clr.cnt_clr_end", if_w1.cnt_clr, if_w0.cnt_clr, 1'b0);

        // Run 6, pause 10, resume: pulse 2 cycles after resume.
        drive(1, 0, 0, 0, '0);
        for (int k = 1; k <= 5; k++) drive(0, 0, 0, 0, '0);
        drive(1, 0, 0, 0, '0);
        @(negedge clk);
        chk_both("pause.running_c6", if_w1.running, if_w0.running, 1'b1);
        for (int k = 7; k <= 15; k++) begin
            drive(0, 0, 0, 0, '0);
            @(negedge clk);
            chk_both("pause.cnt_en",  if_w1.cnt_en,  if_w0.cnt_en,  1'b0);
            chk_both("pause.running", if_w1.running, if_w0.running, 1'b0);
        end
        drive(1, 0, 0, 0, '0);
        drive(0, 0, 0, 0, '0);
        @(negedge clk);
        chk_both("resume.running", if_w1.running, if_w0.running, 1'b1);
        chk_both("resume.cnt_en1", if_w1.cnt_en,  if_w0.cnt_en,  1'b0);

        // Rollover coincident with the resumed pulse.
        drive(0, 0, 0, 1, '0);
        @(negedge clk);
        check("roll.wrap1.cnt_en", 32'(if_w1.cnt_en), 32'h1);
        check("roll.wrap0.cnt_en", 32'(if_w0.cnt_en), 32'h0);
        drive(0, 0, 0, 0, '0);
        @(negedge clk);
        chk_both("roll.overflow", if_w1.overflow, if_w0.overflow, 1'b1);
        check("roll.wrap1.running", 32'(if_w1.running), 32'h1);
        check("roll.wrap0.running", 32'(if_w0.running), 32'h0);
        for (int k = 20; k <= 22; k++) begin
            drive(0, 0, 0, 0, '0);
            @(negedge clk);
            check("sat.wrap0.cnt_en", 32'(if_w0.cnt_en), 32'h0);
            check("wrap.wrap1.cnt_en", 32'(if_w1.cnt_en), 32'(k == 22));
        end

        drive(1, 0, 0, 0, '0);
        drive(0, 0, 0, 0, '0);
        @(negedge clk);
        check("sat.wrap0.ss_ignored", 32'(if_w0.running), 32'h0);
        check("sat.wrap0.overflow",   32'(if_w0.overflow), 32'h1);

        drive(0, 0, 1, 0, 12'h789);
        drive(0, 0, 0, 0, '0);
        @(negedge clk);
        chk_both("lap_sat.lap_valid", if_w1.lap_valid, if_w0.lap_valid, 1'b1);
        check("lap_sat.wrap0.lap_digits", 32'(if_w0.lap_digits), 32'h789);
        drive(0, 0, 0, 0, '0);
        @(negedge clk);
        chk_both("lap_sat.lap_valid_end", if_w1.lap_valid, if_w0.lap_valid, 1'b0);

        drive(0, 1, 0, 0, '0);
        drive(0, 0, 0, 0, '0);
        @(negedge clk);
        chk_both("satclr.cnt_clr",  if_w1.cnt_clr,  if_w0.cnt_clr,  1'b1);
        chk_both("satclr.overflow", if_w1.overflow, if_w0.overflow, 1'b0);
        drive(0, 0, 0, 0, '0);
        @(negedge clk);
        chk_both("satclr.idle_clr", if_w1.cnt_clr, if_w0.cnt_clr, 1'b0);

        drive(0, 0, 1, 0, 12'h456);
        drive(0, 0, 0, 0, '0);
        @(negedge clk);
        chk_both("lap_idle.lap_valid", if_w1.lap_valid, if_w0.lap_valid, 1'b0);
        check("lap_idle.lap_digits", 32'(if_w1.lap_digits), 32'h789);

        drive(1, 0, 0, 0, '0);
        drive(0, 0, 1, 0, 12'h123);
        drive(0, 0, 0, 0, '0);
        @(negedge clk);
        chk_both("lap_run.lap_valid", if_w1.lap_valid, if_w0.lap_valid, 1'b1);
        check("lap_run.lap_digits", 32'(if_w1.lap_digits), 32'h123);

        drive(1, 1, 0, 0, '0);
        drive(0, 0, 0, 0, '0);
        @(negedge clk);
        chk_both("clr_ss.cnt_clr", if_w1.cnt_clr, if_w0.cnt_clr, 1'b1);
        chk_both("clr_ss.running", if_w1.running, if_w0.running, 1'b0);
        drive(0, 0, 0, 0, '0);
        @(negedge clk);
        chk_both("clr_ss.idle_running", if_w1.running, if_w0.running, 1'b0);

        // Asynchronous reset in the middle of a run with overflow set.
        drive(1, 0, 0, 1, '0);
        repeat (5) drive(0, 0, 0, 1, '0);
        @(negedge clk);
        check("prereset.wrap1.overflow", 32'(if_w1.overflow), 32'h1);
        @(posedge clk);
        #2 reset_n = 1'b0;
        dn = 1'b0;
        #1;
        chk_both("async_rst.running",  if_w1.running,  if_w0.running,  1'b0);
        chk_both("async_rst.overflow", if_w1.overflow, if_w0.overflow, 1'b0);
        chk_both("async_rst.cnt_en",   if_w1.cnt_en,   if_w0.cnt_en,   1'b0);
        @(posedge clk);
        #1 reset_n = 1'b1;

        repeat (3000) begin
            @(posedge clk);
            #1;
            ss = ($urandom_range(0, 7) == 0);
            cl = ($urandom_range(0, 39) == 0);
            lp = ($urandom_range(0, 7) == 0);
            dn = ($urandom_range(0, 3) == 0);
            dg = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
        end
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
